// File: rtl/ccsds123_sample_pkg.sv
// Shared types, constants and the LFSR step function for the CCSDS-123
// sample source.
package ccsds123_sample_pkg;

  typedef enum logic [1:0] {MODE_RAMP, MODE_CONST, MODE_LFSR, MODE_COORD} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] THROTTLE_SEED = 16'hACE1;

  // One right-shifting Galois step: the bit shifted out of bit 0 folds the taps back in.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ccsds123_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
// Load has priority over step. RST_VAL selects the state coming out of reset.
module ccsds123_lfsr16
  import ccsds123_sample_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] q
);

  // State register: load a new value, or advance one step.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)  q <= RST_VAL;
    else if (load) q <= load_val;
    else if (step) q <= lfsr_next(q);
  end

endmodule

// File: rtl/ccsds123_sample_source.sv
// AXI-Stream whole-image sample generator, BIP order (z fastest, then x, then y).
// Patterns: RAMP, CONST, LFSR, COORD. Runs of num_frames frames.
// Optional build macro SAMPLE_SOURCE_THROTTLE_EN: a free-running LFSR inserts
// idle cycles between beats. Data content is identical in both builds.
module ccsds123_sample_source
  import ccsds123_sample_pkg::*;
#(
  parameter int NX  = 4,
  parameter int NY  = 4,
  parameter int NZ  = 16,
  parameter int D   = 8,
  parameter int FRW = 8
) (
  input  logic           clk,
  input  logic           aresetn,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [15:0]    seed,
  input  logic [FRW-1:0] num_frames,
  output logic [D-1:0]   m_axis_tdata,
  output logic           m_axis_tvalid,
  input  logic           m_axis_tready,
  output logic           m_axis_tlast,
  output logic           m_axis_tuser,
  output logic           busy,
  output logic           done
);

  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam int ZW = (NZ > 1) ? $clog2(NZ) : 1;
  localparam logic SINGLE = (NX == 1) && (NY == 1) && (NZ == 1);

  state_e         r_state;
  mode_e          r_mode;
  logic [D-1:0]   r_const;
  logic [FRW-1:0] r_nframes;
  logic [FRW-1:0] r_frame;
  logic [D-1:0]   r_idx;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [ZW-1:0]  r_z;
  logic [D-1:0]   r_tdata;
  logic           r_tvalid, r_tlast, r_tuser, r_busy, r_done;

  logic [15:0]    w_seed_fix, w_lfsr_q, w_lfsr_n;
  logic           w_start, w_xfer, w_gap;
  logic           w_z_wrap, w_x_wrap, w_y_wrap, w_frame_end, w_last_beat;
  logic [XW-1:0]  w_x_n;
  logic [YW-1:0]  w_y_n;
  logic [ZW-1:0]  w_z_n;
  logic [FRW-1:0] w_frame_inc;
  logic           w_tlast_n, w_tuser_n;

  assign w_seed_fix = (seed == 16'h0000) ? 16'h0001 : seed;
  assign w_start    = (r_state == S_IDLE) && start;
  assign w_xfer     = (r_state == S_RUN) && r_tvalid && m_axis_tready;
  assign w_lfsr_n   = lfsr_next(w_lfsr_q);

  // Pattern state: holds the value of the beat currently presented.
  ccsds123_lfsr16 #(.RST_VAL(16'h0000)) u_data_lfsr (
    .clk      (clk),
    .aresetn  (aresetn),
    .load     (w_start),
    .load_val (w_seed_fix),
    .step     (w_xfer),
    .q        (w_lfsr_q)
  );

`ifdef SAMPLE_SOURCE_THROTTLE_EN
  logic [15:0] w_thr_q;
  ccsds123_lfsr16 #(.RST_VAL(THROTTLE_SEED)) u_thr_lfsr (
    .clk      (clk),
    .aresetn  (aresetn),
    .load     (1'b0),
    .load_val (16'h0000),
    .step     (1'b1),
    .q        (w_thr_q)
  );
  assign w_gap = (w_thr_q[1:0] == 2'b00);
`else
  assign w_gap = 1'b0;
`endif

  // Next coordinates after a transfer: z carries into x, x into y.
  assign w_z_wrap    = (r_z == ZW'(NZ - 1));
  assign w_x_wrap    = (r_x == XW'(NX - 1));
  assign w_y_wrap    = (r_y == YW'(NY - 1));
  assign w_z_n       = w_z_wrap ? '0 : r_z + ZW'(1);
  assign w_x_n       = !w_z_wrap ? r_x : (w_x_wrap ? '0 : r_x + XW'(1));
  assign w_y_n       = !(w_z_wrap && w_x_wrap) ? r_y : (w_y_wrap ? '0 : r_y + YW'(1));
  assign w_frame_end = w_z_wrap && w_x_wrap && w_y_wrap;
  assign w_frame_inc = r_frame + FRW'(1);
  assign w_last_beat = r_tlast && (w_frame_inc == r_nframes);
  assign w_tlast_n   = (w_x_n == XW'(NX - 1)) && (w_y_n == YW'(NY - 1)) && (w_z_n == ZW'(NZ - 1));
  assign w_tuser_n   = (w_x_n == '0) && (w_y_n == '0) && (w_z_n == '0);

  function automatic logic [D-1:0] pat(input mode_e m, input logic [D-1:0] idx,
                                       input logic [XW-1:0] x, input logic [YW-1:0] y,
                                       input logic [ZW-1:0] z, input logic [15:0] lf,
                                       input logic [D-1:0] cv);
    logic [D-1:0] v;
    case (m)
      MODE_RAMP:  v = idx;
      MODE_CONST: v = cv;
      MODE_LFSR:  v = lf[D-1:0];
      default:    v = D'(32'(x) + 32'(y) + 32'(z));
    endcase
    return v;
  endfunction

  // Run FSM with registered stream outputs; data for the next beat is
  // computed from the post-transfer coordinates so it lands with tvalid.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_mode    <= MODE_RAMP;
      r_const   <= '0;
      r_nframes <= '0;
      r_frame   <= '0;
      r_idx     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_mode    <= mode_e'(mode);
          r_const   <= seed[D-1:0];
          r_nframes <= (num_frames == '0) ? FRW'(1) : num_frames;
          r_frame   <= '0;
          r_idx     <= '0;
          r_x       <= '0;
          r_y       <= '0;
          r_z       <= '0;
          r_tdata   <= pat(mode_e'(mode), '0, '0, '0, '0, w_seed_fix, seed[D-1:0]);
          r_tvalid  <= 1'b1;
          r_tuser   <= 1'b1;
          r_tlast   <= SINGLE;
          r_busy    <= 1'b1;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (!r_tvalid) begin
            r_tvalid <= 1'b1;
          end else if (m_axis_tready) begin
            if (w_last_beat) begin
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
              r_tuser  <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_idx    <= r_idx + D'(1);
              r_x      <= w_x_n;
              r_y      <= w_y_n;
              r_z      <= w_z_n;
              if (w_frame_end) r_frame <= w_frame_inc;
              r_tdata  <= pat(r_mode, r_idx + D'(1), w_x_n, w_y_n, w_z_n, w_lfsr_n, r_const);
              r_tlast  <= w_tlast_n;
              r_tuser  <= w_tuser_n;
              r_tvalid <= !w_gap;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_ccsds123_sample_source.sv
// Directed bench for ccsds123_sample_source at default geometry (4x4x16, D=8).
module tb_ccsds123_sample_source;

  localparam int NX = 4, NY = 4, NZ = 16, D = 8, FRW = 8;
  localparam int FSZ = NX * NY * NZ;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [15:0]    seed = 16'h0000;
  logic [FRW-1:0] num_frames = '0;
  logic [D-1:0]   m_axis_tdata;
  logic           m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, done;
  logic           m_axis_tready = 1'b1;

  int nchecks = 0;
  int nerrors = 0;

  ccsds123_sample_source #(.NX(NX), .NY(NY), .NZ(NZ), .D(D), .FRW(FRW)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .start         (start),
    .mode          (mode),
    .seed          (seed),
    .num_frames    (num_frames),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  property p_hold;
    @(posedge clk) disable iff (!aresetn)
      (m_axis_tvalid && !m_axis_tready) |=> (m_axis_tvalid && $stable(m_axis_tdata));
  endproperty
  a_hold: assert property (p_hold) else $error("FAIL hold: tvalid/tdata changed during stall");

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] seed;
    logic [7:0]  frames;
    bit          toggle;
    bit          inj;
    int          beats;
    logic [7:0]  b0, b1;
    bit          tail;
    logic [7:0]  b99, blast;
  } tv_t;

  tv_t tv[6];
  int  sig[6];

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic run(input tv_t v, output int signature);
    int beats, cyc, first_cyc, last_cyc, done_cyc, j, e;
    int err_data, err_flags, err_stall, err_busy;
    logic [15:0] ls;
    logic [7:0]  pd, d0, d1, d99, dl;
    logic        pv, pr, got_done;
    beats = 0; cyc = 0; first_cyc = 0; last_cyc = 0; done_cyc = -1;
    err_data = 0; err_flags = 0; err_stall = 0; err_busy = 0;
    pv = 0; pr = 0; pd = 0; d0 = 0; d1 = 0; d99 = 0; dl = 0;
    got_done = 0; signature = 0;
    ls = (v.seed == 16'h0000) ? 16'h0001 : v.seed;
    @(negedge clk);
    mode = v.mode; seed = v.seed; num_frames = v.frames; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'(v.mode + 2'd1); seed = 16'h5A5A; num_frames = 8'd3;
    chk("start_latency_tvalid", m_axis_tvalid, 1);
    chk("start_busy", busy, 1);
    while (!got_done && cyc < 5000) begin
      if (pv && !pr && (!m_axis_tvalid || m_axis_tdata != pd)) err_stall++;
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
        if (busy) err_busy++;
      end else begin
        if (!busy) err_busy++;
        m_axis_tready = v.toggle ? (cyc % 2 == 0) : 1'b1;
        start = (v.inj && beats == 50) ? 1'b1 : 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          j = beats % FSZ;
          case (v.mode)
            2'd0:    e = beats % 256;
            2'd1:    e = int'(v.seed[7:0]);
            2'd2:    e = int'(ls[7:0]);
            default: e = (j % NZ) + ((j / NZ) % NX) + (j / (NZ * NX));
          endcase
          if (int'(m_axis_tdata) != e) begin
            if (err_data == 0) $display("FAIL data beat %0d: got %0d expected %0d", beats, m_axis_tdata, e);
            err_data++;
          end
          if (m_axis_tuser != (j == 0) || m_axis_tlast != (j == FSZ - 1)) err_flags++;
          if (beats == 0) begin first_cyc = cyc; d0 = m_axis_tdata; end
          if (beats == 1) d1 = m_axis_tdata;
          if (beats == 99) d99 = m_axis_tdata;
          dl = m_axis_tdata;
          last_cyc = cyc;
          signature = signature * 31 + int'(m_axis_tdata);
          ls = lfsr_model(ls);
          beats++;
        end
        pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    m_axis_tready = 1'b1;
    chk("done_seen", got_done, 1);
    chk("beat_count", beats, v.beats);
    chk("data_errors", err_data, 0);
    chk("tuser_tlast_errors", err_flags, 0);
    chk("stall_hold_errors", err_stall, 0);
    chk("busy_errors", err_busy, 0);
    chk("done_timing", done_cyc, last_cyc + 1);
    chk("beat0_data", d0, v.b0);
    chk("beat1_data", d1, v.b1);
    if (v.tail) begin
      chk("beat99_data", d99, v.b99);
      chk("last_data", dl, v.blast);
    end
`ifndef SAMPLE_SOURCE_THROTTLE_EN
    if (!v.toggle) chk("back_to_back", last_cyc - first_cyc, v.beats - 1);
`endif
    @(negedge clk);
    chk("post_done_pulse", done, 0);
    chk("post_busy", busy, 0);
    chk("post_tvalid", m_axis_tvalid, 0);
  endtask

  initial begin
    int n, dn, s;
    tv[0] = '{2'd0, 16'h0000, 8'd1, 1'b0, 1'b0, 256, 8'd0,   8'd1,   1'b1, 8'd99,  8'd255};
    tv[1] = '{2'd0, 16'h0000, 8'd2, 1'b1, 1'b0, 512, 8'd0,   8'd1,   1'b1, 8'd99,  8'd255};
    tv[2] = '{2'd1, 16'h00A5, 8'd0, 1'b0, 1'b0, 256, 8'hA5,  8'hA5,  1'b1, 8'hA5,  8'hA5};
    tv[3] = '{2'd3, 16'h0000, 8'd1, 1'b0, 1'b1, 256, 8'd0,   8'd1,   1'b1, 8'd6,   8'd21};
    tv[4] = '{2'd2, 16'h0000, 8'd1, 1'b0, 1'b0, 256, 8'h01,  8'h00,  1'b0, 8'd0,   8'd0};
    tv[5] = tv[4];

    #12;
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tlast", m_axis_tlast, 0);
    chk("reset_tuser", m_axis_tuser, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run(tv[i], s);
      sig[i] = s;
      if (i == 5) chk("lfsr_rerun_identical", sig[5], sig[4]);
    end

    // Abort mid-run with reset while beat 100 is being presented.
    @(negedge clk);
    mode = 2'd0; seed = 16'h0000; num_frames = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 400 && n < 100; c++) begin
      if (m_axis_tvalid && m_axis_tready) n++;
      @(negedge clk);
    end
    chk("abort_beat100_valid", m_axis_tvalid, 1);
    chk("abort_beat100_data", m_axis_tdata, 100);
    #2 aresetn = 1'b0;
    #1;
    chk("abort_tvalid_async", m_axis_tvalid, 0);
    chk("abort_busy_async", busy, 0);
    dn = 0;
    repeat (3) begin @(negedge clk); dn = dn | int'(done); end
    aresetn = 1'b1;
    repeat (4) begin @(negedge clk); dn = dn | int'(done); end
    chk("abort_no_done", dn, 0);
    run(tv[0], s);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
